rr_stream_mux: RTL and testbench

//  N-input, W-bit registered stream multiplexer; successor of the 2:1 combinational mux.

---
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/rr_stream_mux_checker.sv | 24 ++
 rtl/rr_stream_mux.sv | 103 ++++++++++
 tb/tb_rr_stream_mux.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: fixed priority (MODE=0) or round-robin from ptr (MODE=1).
// Uses a double-width request vector so the wrap-around search is a single priority scan.
module rr_arbiter #(
  parameter  int N    = 4,
  parameter  int MODE = 1,
  localparam int CW   = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [CW-1:0] gnt_idx
);

  logic [CW-1:0]  eff_ptr_s;
  logic [2*N-1:0] req_dbl_s;
  logic [2*N-1:0] mask_s;
  logic [2*N-1:0] masked_s;
  logic           found_s;
  logic [CW-1:0]  idx_s;

  // Mask off positions below the pointer in the lower copy; the upper copy supplies the wrap.
  always_comb begin
    if (MODE == 1) begin
      eff_ptr_s = ptr;
    end else begin
      eff_ptr_s = {CW{1'b0}};
    end
    req_dbl_s = {req, req};
    for (int j = 0; j < 2*N; j++) begin
      if (j >= int'(eff_ptr_s)) begin
        mask_s[j] = 1'b1;
      end else begin
        mask_s[j] = 1'b0;
      end
    end
    masked_s = req_dbl_s & mask_s;
  end

  // Lowest set bit of the masked vector, folded back onto the channel range.
  always_comb begin
    found_s = 1'b0;
    idx_s   = {CW{1'b0}};
    for (int j = 0; j < 2*N; j++) begin
      if (!found_s && masked_s[j]) begin
        found_s = 1'b1;
        idx_s   = CW'(j % N);
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant derived from the encoded winner.
  always_comb begin
    gnt     = {N{1'b0}};
    gnt_idx = idx_s;
    if (found_s) begin
      gnt[idx_s] = 1'b1;
    end else begin
      gnt = {N{1'b0}};
    end
  end

endmodule

// File: rtl/rr_stream_mux_checker.sv
// Protocol properties for rr_stream_mux: single-grant ready and a held output while stalled.
module rr_stream_mux_checker #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic [N-1:0]  in_valid,
  input logic [N-1:0]  in_ready,
  input logic          out_valid,
  input logic          out_ready,
  input logic [W-1:0]  out_data,
  input logic [CW-1:0] out_ch
);

  a_ready_onehot: assert property (@(posedge clk) $onehot0(in_ready));

  a_ready_needs_valid: assert property (@(posedge clk) ((in_ready & ~in_valid) == {N{1'b0}}));

  a_stall_holds: assert property (@(posedge clk)
    (!rst && out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ch)));

endmodule

// File: rtl/rr_stream_mux.sv
// N-input registered stream multiplexer with internal arbitration and valid/ready on every port.
// The output register refills in the same cycle it drains, giving one word per cycle.
module rr_stream_mux #(
  parameter  int N    = 4,
  parameter  int W    = 8,
  parameter  int MODE = 1,
  localparam int CW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_ch,
  input  logic           out_ready
);

  logic          load_s;
  logic          any_valid_s;
  logic [N-1:0]  gnt_s;
  logic [CW-1:0] gnt_idx_s;
  logic [CW-1:0] ptr_next_s;
  logic [W-1:0]  sel_data_s;

  logic          out_valid_r;
  logic [W-1:0]  out_data_r;
  logic [CW-1:0] out_ch_r;
  logic [CW-1:0] rr_ptr_r;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Load/ready decision, data select and pointer successor.
  always_comb begin
    load_s      = !out_valid_r || out_ready;
    any_valid_s = |in_valid;
    sel_data_s  = in_data[int'(gnt_idx_s)*W +: W];
    if (gnt_idx_s == CW'(N-1)) begin
      ptr_next_s = {CW{1'b0}};
    end else begin
      ptr_next_s = gnt_idx_s + CW'(1);
    end
    if (rst) begin
      in_ready = {N{1'b0}};
    end else if (load_s) begin
      in_ready = gnt_s;
    end else begin
      in_ready = {N{1'b0}};
    end
  end

  // Output register and round-robin pointer; the pointer moves only on an accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_ch_r    <= {CW{1'b0}};
      rr_ptr_r    <= {CW{1'b0}};
    end else if (load_s) begin
      if (any_valid_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= sel_data_s;
        out_ch_r    <= gnt_idx_s;
        if (MODE == 1) begin
          rr_ptr_r <= ptr_next_s;
        end else begin
          rr_ptr_r <= {CW{1'b0}};
        end
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;

  rr_stream_mux_checker #(
    .N  (N),
    .W  (W),
    .CW (CW)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid_r),
    .out_ready (out_ready),
    .out_data  (out_data_r),
    .out_ch    (out_ch_r)
  );

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: a round-robin and a fixed-priority instance share stimulus;
// a vector table checks grants, and a per-instance scoreboard checks every drained word.
module tb_rr_stream_mux;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;

  logic [N-1:0]   rdy_rr, rdy_fp;
  logic           ov_rr, ov_fp;
  logic [W-1:0]   od_rr, od_fp;
  logic [CW-1:0]  och_rr, och_fp;

  rr_stream_mux #(.N(N), .W(W), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_rr),
    .out_valid(ov_rr), .out_data(od_rr), .out_ch(och_rr), .out_ready(out_ready)
  );

  rr_stream_mux #(.N(N), .W(W), .MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_fp),
    .out_valid(ov_fp), .out_data(od_fp), .out_ch(och_fp), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [CW-1:0] ch;
  } word_t;

  typedef struct {
    logic         rst;
    logic [N-1:0] iv;
    logic         ordy;
    logic [N-1:0] e_rr;
    logic [N-1:0] e_fp;
  } vec_t;

  word_t         q_rr[$];
  word_t         q_fp[$];
  logic [CW-1:0] ptr_rr;
  int            served[N];
  int            n_pass  = 0;
  int            n_total = 0;
  int            cyc     = 0;
  vec_t          tbl[23];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Reference grant: scan upward from p with wrap.
  function automatic logic [N-1:0] ref_grant(input logic [N-1:0] v, input logic [CW-1:0] p);
    logic [N-1:0] g;
    logic         hit;
    g   = '0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(p) + k) % N;
      if (!hit && v[idx]) begin
        g[idx] = 1'b1;
        hit    = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [CW-1:0] enc(input logic [N-1:0] g);
    logic [CW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (g[k]) r = CW'(k);
    end
    return r;
  endfunction

  // Pre-edge: check in_ready, pop/compare drained word, push newly accepted word.
  task automatic model_pre(input int d, input logic [N-1:0] rdy, input logic [W-1:0] od,
                           input logic [CW-1:0] och);
    string         tag;
    int            qs;
    logic [CW-1:0] p;
    logic          ld;
    logic [N-1:0]  g;
    word_t         w;
    tag = (d == 0) ? "rr" : "fp";
    qs  = (d == 0) ? q_rr.size() : q_fp.size();
    p   = (d == 0) ? ptr_rr : '0;
    ld  = (qs == 0) || out_ready;
    g   = ref_grant(in_valid, p);
    chk({tag, "_in_ready"}, 32'(rdy), (rst || !ld) ? 32'd0 : 32'(g));
    if (rst) begin
      if (d == 0) begin
        q_rr.delete();
        ptr_rr = '0;
      end else begin
        q_fp.delete();
      end
    end else begin
      if (qs != 0 && out_ready) begin
        if (d == 0) w = q_rr.pop_front();
        else        w = q_fp.pop_front();
        chk({tag, "_out_data"}, 32'(od), 32'(w.data));
        chk({tag, "_out_ch"}, 32'(och), 32'(w.ch));
        if (d == 0) served[och]++;
      end
      if (ld && (|in_valid)) begin
        w.ch   = enc(g);
        w.data = in_data[int'(w.ch)*W +: W];
        if (d == 0) begin
          q_rr.push_back(w);
          ptr_rr = (w.ch == CW'(N-1)) ? '0 : w.ch + CW'(1);
        end else begin
          q_fp.push_back(w);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [N-1:0] iv, input logic ordy,
                      input logic use_tbl, input logic [N-1:0] e_rr, input logic [N-1:0] e_fp);
    rst       = r;
    in_valid  = iv;
    out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      in_data[i*W +: W] = 8'((i << 4) | (cyc & 15)) ^ 8'($urandom_range(0, 1) << 3);
    end
    #1;
    if (use_tbl) begin
      chk("tbl_rr_ready", 32'(rdy_rr), 32'(e_rr));
      chk("tbl_fp_ready", 32'(rdy_fp), 32'(e_fp));
    end
    model_pre(0, rdy_rr, od_rr, och_rr);
    model_pre(1, rdy_fp, od_fp, och_fp);
    @(posedge clk);
    #1;
    chk("rr_out_valid", 32'(ov_rr), 32'(q_rr.size() != 0));
    chk("fp_out_valid", 32'(ov_fp), 32'(q_fp.size() != 0));
    if (r) begin
      chk("rst_out_data", 32'({od_rr, od_fp}), 32'd0);
      chk("rst_out_ch", 32'({och_rr, och_fp}), 32'd0);
    end
    cyc++;
  endtask

  initial begin
    int total;
    ptr_rr = '0;
    // reset with all valid; RR sweep; fixed-priority on 1010; stall; sparse wrap; idle; reset mid-stall
    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0001};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0001};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 4'b0001};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 4'b0001};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0001};
    tbl[7]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 4'b0010};
    tbl[8]  = '{1'b0, 4'b1010, 1'b1, 4'b1000, 4'b0010};
    tbl[9]  = '{1'b0, 4'b1010, 1'b1, 4'b0010, 4'b0010};
    tbl[10] = '{1'b0, 4'b1010, 1'b0, 4'b0000, 4'b0000};
    tbl[11] = '{1'b0, 4'b1010, 1'b0, 4'b0000, 4'b0000};
    tbl[12] = '{1'b0, 4'b1010, 1'b0, 4'b0000, 4'b0000};
    tbl[13] = '{1'b0, 4'b1010, 1'b1, 4'b1000, 4'b0010};
    tbl[14] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0010};
    tbl[15] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0001};
    tbl[16] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0001};
    tbl[17] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000};
    tbl[18] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000};
    tbl[19] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0001};
    tbl[20] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000};
    tbl[21] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000};
    tbl[22] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0001};

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].ordy, 1'b1, tbl[i].e_rr, tbl[i].e_fp);
    end

    // Randomised traffic with occasional resets; scoreboard does the checking.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0), N'($urandom), ($urandom_range(0, 3) != 0),
           1'b0, '0, '0);
    end

    // Fairness: all channels valid, random backpressure, 16 drained words.
    step(1'b1, 4'b1111, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < N; i++) served[i] = 0;
    total = 0;
    for (int i = 0; i < 200 && total < 4*N; i++) begin
      step(1'b0, 4'b1111, ($urandom_range(0, 2) != 0), 1'b0, '0, '0);
      total = 0;
      for (int k = 0; k < N; k++) total += served[k];
    end
    for (int k = 0; k < N; k++) begin
      chk("rr_fairness", 32'(served[k]), 32'd4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
